// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared defaults and FSM encoding for the multi-port data memory.
//   DEF_WIDTH / DEF_DEPTH / DEF_PTR_W : default word width, word count, pointer width
//   state_t, ST_CLR, ST_IDLE          : clear-sequencer state encoding
package data_mem_pkg;

  localparam int DEF_WIDTH = 256;
  localparam int DEF_DEPTH = 6;
  localparam int DEF_PTR_W = 3;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLR  = 1'b0;
  localparam state_t ST_IDLE = 1'b1;

endpackage

// File: rtl/data_mem_clr_seq.sv
// data_mem_clr_seq: clear sequencer. Walks clr_cnt over 0..DEPTH-1, one word per
// cycle, then returns to IDLE.
//   clk, reset : clock, asynchronous active-high reset (forces CLR, count 0)
//   clear      : synchronous request to (re)start the clear walk at word 0
//   busy       : high exactly while in CLR
//   clr_cnt    : word being zeroed this cycle
//   state      : current FSM state (debug visibility)
module data_mem_clr_seq
  import data_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic             busy,
  output logic [PTR_W-1:0] clr_cnt,
  output state_t           state
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLR;
      clr_cnt <= '0;
    end else if (clear) begin
      // clear always restarts the walk, whether idle or mid-sequence
      state   <= ST_CLR;
      clr_cnt <= '0;
    end else if (state == ST_CLR) begin
      if (clr_cnt == LAST) begin
        state   <= ST_IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign busy = (state == ST_CLR);

endmodule

// File: rtl/data_mem_mp.sv
// data_mem_mp: byte-maskable word memory with one write port and two read ports.
//   clk, reset            : clock, asynchronous active-high reset (outputs only)
//   clear                 : synchronous request to zero the whole array
//   write_data            : write enable; write_data_pointer / data_to_write / write_mask
//   read_data             : read enable for both ports; pointer1 / pointer2
//   data1, data2          : registered read data
//   rd_valid              : data1/data2 were loaded by the previous cycle's read
//   busy                  : clear sequence in progress, accesses are ignored
//   err_oob               : one-cycle pulse for an accepted access with pointer >= DEPTH
//
// Read contract: a read is accepted at a rising edge when read_data=1, busy=0 and
// clear=0. data1/data2 then hold the result from the following cycle on and
// rd_valid is 1 for exactly that one cycle; without an accepted read rd_valid is 0
// and data1/data2 keep their last value. There is no back-pressure.
module data_mem_mp
  import data_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               write_data,
  input  logic [PTR_W-1:0]   write_data_pointer,
  input  logic [WIDTH-1:0]   data_to_write,
  input  logic [WIDTH/8-1:0] write_mask,
  input  logic               read_data,
  input  logic [PTR_W-1:0]   pointer1,
  input  logic [PTR_W-1:0]   pointer2,
  output logic [WIDTH-1:0]   data1,
  output logic [WIDTH-1:0]   data2,
  output logic               rd_valid,
  output logic               busy,
  output logic               err_oob
);

  localparam int             NB      = WIDTH / 8;
  localparam logic [PTR_W:0] DEPTH_P = DEPTH[PTR_W:0];

  function automatic logic in_range(input logic [PTR_W-1:0] p);
    return {1'b0, p} < DEPTH_P;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] clr_cnt;
  state_t           seq_state;

  data_mem_clr_seq #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_clr_seq (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .busy    (busy),
    .clr_cnt (clr_cnt),
    .state   (seq_state)
  );

  // Accesses only count in IDLE and lose to a same-cycle clear.
  logic accept;
  logic wr_in, p1_in, p2_in;
  logic wr_fire, rd_fire;
  logic clr_we;

  assign accept  = (seq_state == ST_IDLE) && !clear;
  assign wr_in   = in_range(write_data_pointer);
  assign p1_in   = in_range(pointer1);
  assign p2_in   = in_range(pointer2);
  assign wr_fire = accept && write_data && wr_in;
  assign rd_fire = accept && read_data;
  // no zeroing while reset is held; the walk restarts after release anyway
  assign clr_we  = busy && !reset;

  // Byte merge: masked lanes take new data, the rest keep the stored word.
  logic [WIDTH-1:0] wr_old, wr_word;

  always_comb begin
    wr_old = '0;
    if (wr_in) wr_old = mem[write_data_pointer];
    wr_word = wr_old;
    for (int k = 0; k < NB; k++) begin
      if (write_mask[k]) wr_word[8*k +: 8] = data_to_write[8*k +: 8];
    end
  end

  // Write-first read path: a same-cycle write to the same word forwards the merge.
  logic [WIDTH-1:0] rd1_word, rd2_word;

  always_comb begin
    rd1_word = '0;
    rd2_word = '0;
    if (p1_in) begin
      if (wr_fire && (pointer1 == write_data_pointer)) rd1_word = wr_word;
      else                                             rd1_word = mem[pointer1];
    end
    if (p2_in) begin
      if (wr_fire && (pointer2 == write_data_pointer)) rd2_word = wr_word;
      else                                             rd2_word = mem[pointer2];
    end
  end

  // Storage carries no reset; it is zeroed by the clear walk.
  always_ff @(posedge clk) begin
    if (clr_we)       mem[clr_cnt]            <= '0;
    else if (wr_fire) mem[write_data_pointer] <= wr_word;
  end

  logic oob_next;
  assign oob_next = accept && ((write_data && !wr_in) ||
                               (read_data && (!p1_in || !p2_in)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data1    <= '0;
      data2    <= '0;
      rd_valid <= 1'b0;
      err_oob  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      err_oob  <= oob_next;
      if (rd_fire) begin
        data1 <= rd1_word;
        data2 <= rd2_word;
      end
    end
  end

endmodule
